div_unit: RTL and testbench

//  Iterative RV M-extension divider (DIV/DIVU/REM/REMU) in the Execute stage.
//  It is the source of the hazard unit's DivStalled input: it holds D/F/E stalled while iterating.
//  It releases the stall in the cycle its result is valid, so the pipeline advances with the result.
//  One radix-2 restoring step per cycle; signed ops are done via magnitudes plus sign fix-up.

---
 rtl/div_if.sv | 23 ++
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Execute-stage request/response bundle between the pipeline and the iterative divider.
interface div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_E;
  logic [1:0]      op_E;
  logic [XLEN-1:0] rs1_val_E;
  logic [XLEN-1:0] rs2_val_E;
  logic            kill_E;
  logic            DivStalled;
  logic            div_valid;
  logic [XLEN-1:0] div_result;

  modport master (
    output start_E, op_E, rs1_val_E, rs2_val_E, kill_E,
    input  DivStalled, div_valid, div_result
  );

  modport slave (
    input  start_E, op_E, rs1_val_E, rs2_val_E, kill_E,
    output DivStalled, div_valid, div_result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; stalls the pipeline while iterating.
// Optional `DIV_EARLY_OUT_EN: finishes in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic   clk,
  input logic   rst_n,
  div_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic            stall;
  logic            valid;

  logic            op_signed, sign_a, sign_b, div_zero, overflow;
  logic [XLEN-1:0] abs_a, abs_b, min_int, special_res;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] rem_step, quo_step, rem_fix, quo_fix;

  always_comb begin
    op_signed   = ~bus.op_E[0];
    sign_a      = op_signed & bus.rs1_val_E[XLEN-1];
    sign_b      = op_signed & bus.rs2_val_E[XLEN-1];
    abs_a       = sign_a ? ('0 - bus.rs1_val_E) : bus.rs1_val_E;
    abs_b       = sign_b ? ('0 - bus.rs2_val_E) : bus.rs2_val_E;
    min_int     = {1'b1, {(XLEN-1){1'b0}}};
    div_zero    = (bus.rs2_val_E == '0);
    overflow    = op_signed && (bus.rs1_val_E == min_int) && (bus.rs2_val_E == '1);
    if (div_zero) special_res = bus.op_E[1] ? bus.rs1_val_E : '1;
    else          special_res = bus.op_E[1] ? '0 : min_int;
  end

  // Shift in XLEN+1 bits so divisors with the top bit set still compare correctly.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, dvs_q};
    rem_step = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ~trial[XLEN]};
    rem_fix  = neg_rem_q ? ('0 - rem_step) : rem_step;
    quo_fix  = neg_quo_q ? ('0 - quo_step) : quo_step;
  end

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    stall     = 1'b0;
    valid     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_E && !bus.kill_E) begin
          stall     = 1'b1;
          is_rem_d  = bus.op_E[1];
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          rem_d     = '0;
          cnt_d     = CNT_W'(XLEN);
          if (div_zero || overflow) begin
            res_d   = special_res;
            state_d = StDone;
`ifdef DIV_EARLY_OUT_EN
          end else if (abs_a < abs_b) begin
            res_d   = bus.op_E[1] ? bus.rs1_val_E : '0;
            state_d = StDone;
`endif
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          res_d   = is_rem_q ? rem_fix : quo_fix;
          state_d = StDone;
        end
      end
      StDone: begin
        valid   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A flush abandons the op without touching the visible result.
    if (bus.kill_E) begin
      state_d = StIdle;
      res_d   = res_q;
      stall   = 1'b0;
      valid   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Stall is combinational from start_E, so mask it while reset is asserted.
  assign bus.DivStalled = stall & rst_n;
  assign bus.div_valid  = valid;
  assign bus.div_result = res_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results queued on issue, compared on div_valid.
module tb_div_unit;
  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

`ifdef DIV_EARLY_OUT_EN
  localparam int EarlyLat = 1;
`else
  localparam int EarlyLat = 33;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb[$];

  div_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op, checks stall every cycle until div_valid, then latency/result/hold.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int          cyc;
    bit          got;
    logic [31:0] e;
    sb.push_back(exp);
    e   = exp;
    @(posedge clk); #1;
    bus.start_E   = 1'b1;
    bus.kill_E    = 1'b0;
    bus.op_E      = op;
    bus.rs1_val_E = a;
    bus.rs2_val_E = b;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 60) begin
      @(negedge clk);
      if (bus.div_valid === 1'b1) begin
        got = 1'b1;
        e   = sb.pop_front();
        check("latency", 32'(cyc), 32'(lat));
        check("stall_at_valid", {31'b0, bus.DivStalled}, 32'd0);
        check("result", bus.div_result, e);
      end else begin
        check("stall_busy", {31'b0, bus.DivStalled}, 32'd1);
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("valid_seen", {31'b0, got}, 32'd1);
    if (!got) e = sb.pop_front();
    @(posedge clk); #1;
    bus.start_E = 1'b0;
    @(negedge clk);
    check("valid_pulse", {31'b0, bus.div_valid}, 32'd0);
    check("result_hold", bus.div_result, e);
  endtask

  initial begin
    bus.start_E   = 1'b0;
    bus.kill_E    = 1'b0;
    bus.op_E      = 2'b00;
    bus.rs1_val_E = '0;
    bus.rs2_val_E = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", {31'b0, bus.DivStalled}, 32'd0);
    check("rst_valid", {31'b0, bus.div_valid}, 32'd0);
    check("rst_result", bus.div_result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Normal path and sign rules
    run_op(OpDivu, 32'd100, 32'd7, 32'd14, 33);
    run_op(OpRemu, 32'd100, 32'd7, 32'd2, 33);
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op(OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op(OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op(OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op(OpDiv, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op(OpRem, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op(OpDivu, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 33);
    run_op(OpRemu, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
    run_op(OpDiv, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

    // Divide by zero and overflow
    run_op(OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(OpRemu, 32'd5, 32'd0, 32'd5, 1);
    run_op(OpDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(OpRem, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Early-out candidates: identical results either way
    run_op(OpDivu, 32'd3, 32'd10, 32'd0, EarlyLat);
    run_op(OpRemu, 32'd3, 32'd10, 32'd3, EarlyLat);

    // Kill in cycle 10 of a DIVU, then a fresh DIVU 9/3 in cycle 11
    @(posedge clk); #1;
    bus.start_E   = 1'b1;
    bus.op_E      = OpDivu;
    bus.rs1_val_E = 32'd1000;
    bus.rs2_val_E = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("kill_pre_stall", {31'b0, bus.DivStalled}, 32'd1);
      check("kill_pre_valid", {31'b0, bus.div_valid}, 32'd0);
      @(posedge clk); #1;
    end
    bus.kill_E = 1'b1;
    @(negedge clk);
    check("kill_stall", {31'b0, bus.DivStalled}, 32'd0);
    check("kill_valid", {31'b0, bus.div_valid}, 32'd0);
    run_op(OpDivu, 32'd9, 32'd3, 32'd3, 33);

    // Killed op must never produce a valid afterwards
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_valid", {31'b0, bus.div_valid}, 32'd0);
    end

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    bus.start_E   = 1'b1;
    bus.op_E      = OpDivu;
    bus.rs1_val_E = 32'd100;
    bus.rs2_val_E = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stall", {31'b0, bus.DivStalled}, 32'd0);
    check("arst_valid", {31'b0, bus.div_valid}, 32'd0);
    check("arst_result", bus.div_result, 32'd0);
    bus.start_E = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_rst_valid", {31'b0, bus.div_valid}, 32'd0);
    end
    run_op(OpDivu, 32'd9, 32'd3, 32'd3, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
